// File: rtl/axi4_slave_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem_arbiter_if
//
// Purpose : bundles the requester-side (write/read channel) and RAM-side
//           signals of the single-port memory arbiter.
//
// Signals :
//   wr_req/wr_addr/wr_data/wr_byte_en  write request and payload
//   wr_gnt                             write accepted this cycle
//   rd_req/rd_addr                     read request and address
//   rd_gnt                             read accepted this cycle
//   rd_data/rd_data_valid              read return (fixed latency)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_be  RAM command
//   ram_rdata                          RAM read data (1-cycle latency)
//
// Modports:
//   slave  - the arbiter
//   master - requesters plus the RAM model (everything outside the arbiter)
// ---------------------------------------------------------------------------
interface axi4_slave_mem_arbiter_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 12
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic                     wr_req;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [BE_WIDTH-1:0]      wr_byte_en;
    logic                     wr_gnt;
    logic                     rd_req;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic                     rd_gnt;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_data_valid;

    // RAM side
    logic                     ram_en;
    logic                     ram_we;
    logic [MEM_ADDR_BITS-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic [BE_WIDTH-1:0]      ram_be;
    logic [DATA_WIDTH-1:0]    ram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_byte_en,
        input  rd_req, rd_addr,
        input  ram_rdata,
        output wr_gnt, rd_gnt, rd_data, rd_data_valid,
        output ram_en, ram_we, ram_addr, ram_wdata, ram_be
    );

    modport master (
        output wr_req, wr_addr, wr_data, wr_byte_en,
        output rd_req, rd_addr,
        output ram_rdata,
        input  wr_gnt, rd_gnt, rd_data, rd_data_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata, ram_be
    );
endinterface

// File: rtl/axi4_slave_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem_arbiter
//
// Purpose : shares one single-port synchronous RAM (1-cycle read latency)
//           between a write requester and a read requester. Arbitration is
//           write-priority with a starvation guard; optionally one dead
//           cycle is inserted whenever the grant direction changes.
//           Read data returns two cycles after the read grant.
//
// Ports   :
//   CLK  - clock
//   RST  - synchronous active-high reset
//   bus  - axi4_slave_mem_arbiter_if.slave (requester + RAM signals)
//
// Parameters:
//   ADDR_WIDTH     requester address width
//   DATA_WIDTH     data width, multiple of 8
//   MEM_ADDR_BITS  RAM word-index width (<= ADDR_WIDTH)
//   MAX_WR_STREAK  write grants allowed in a row while a read waits (1..255)
//   TURNAROUND     1 = one idle cycle on grant direction change
// ---------------------------------------------------------------------------
module axi4_slave_mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 12,
    parameter int MAX_WR_STREAK = 4,
    parameter int TURNAROUND    = 0
) (
    input logic                     CLK,
    input logic                     RST,
    axi4_slave_mem_arbiter_if.slave bus
);
    localparam int         BE_WIDTH   = DATA_WIDTH / 8;
    localparam logic [7:0] STREAK_MAX = 8'(MAX_WR_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } state_e;

    // Registered state
    state_e                   state_q,     state_d;
    logic [7:0]               wr_streak_q, wr_streak_d;
    logic                     rd_pend_q,   rd_pend_d;   // read strobe issued last cycle
    logic                     rd_valid_q,  rd_valid_d;
    logic [DATA_WIDTH-1:0]    rd_data_q,   rd_data_d;
    logic                     ram_we_q,    ram_we_d;
    logic [MEM_ADDR_BITS-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
    logic [BE_WIDTH-1:0]      ram_be_q,    ram_be_d;

    // Arbitration
    logic                  win_wr;
    logic                  win_rd;
    logic                  turn_stall;
    logic                  wr_gnt;
    logic                  rd_gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] unused_sel_addr;

    // Upper address bits are intentionally dropped; this keeps the full
    // selected address visibly consumed.
    assign unused_sel_addr = sel_addr;

    // -----------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        win_wr     = 1'b0;
        win_rd     = 1'b0;
        turn_stall = 1'b0;
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;

        // Write wins unless the starvation guard has tripped with a read waiting.
        win_wr = bus.wr_req && !(bus.rd_req && (wr_streak_q == STREAK_MAX));
        win_rd = bus.rd_req && !win_wr;

        // A direction change out of WR or RD costs one dead cycle. From IDLE
        // and from TURN the winner is granted straight away.
        if (TURNAROUND != 0) begin
            turn_stall = ((state_q == WR) && win_rd) || ((state_q == RD) && win_wr);
        end

        wr_gnt = !RST && win_wr && !turn_stall;
        rd_gnt = !RST && win_rd && !turn_stall;
    end

    // -----------------------------------------------------------------------
    // Next state: FSM, streak counter, RAM command hold registers, read pipe
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wr_streak_d = wr_streak_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        sel_addr    = wr_gnt ? bus.wr_addr : bus.rd_addr;

        // FSM
        if (wr_gnt) begin
            state_d = WR;
        end else if (rd_gnt) begin
            state_d = RD;
        end else if (turn_stall) begin
            state_d = TURN;
        end else if (!bus.wr_req && !bus.rd_req) begin
            state_d = IDLE;
        end

        // Streak counts writes that jumped ahead of a waiting read. It is
        // frozen on the dead cycle so the pending direction change cannot
        // reset or advance it.
        if (turn_stall) begin
            wr_streak_d = wr_streak_q;
        end else if (rd_gnt || !bus.rd_req) begin
            wr_streak_d = 8'd0;
        end else if (wr_gnt && (wr_streak_q != STREAK_MAX)) begin
            wr_streak_d = wr_streak_q + 8'd1;
        end

        // RAM command: updated on a grant, held otherwise.
        if (wr_gnt) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = sel_addr[MEM_ADDR_BITS-1:0];
            ram_wdata_d = bus.wr_data;
            ram_be_d    = bus.wr_byte_en;
        end else if (rd_gnt) begin
            ram_we_d   = 1'b0;
            ram_addr_d = sel_addr[MEM_ADDR_BITS-1:0];
            ram_be_d   = '0;
        end

        // While in reset the combinational RAM outputs show the reset values.
        if (RST) begin
            state_d     = IDLE;
            wr_streak_d = 8'd0;
            ram_we_d    = 1'b0;
            ram_addr_d  = '0;
            ram_wdata_d = '0;
            ram_be_d    = '0;
        end
    end

    // Read return pipeline: grant in N, RAM data valid in N+1, registered
    // into rd_data at the end of N+1, presented in N+2.
    always_comb begin
        rd_pend_d  = rd_gnt;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? bus.ram_rdata : rd_data_q;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wr_streak_q <= 8'd0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_streak_q <= wr_streak_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.wr_gnt        = wr_gnt;
    assign bus.rd_gnt        = rd_gnt;
    assign bus.ram_en        = wr_gnt || rd_gnt;
    assign bus.ram_we        = ram_we_d;
    assign bus.ram_addr      = ram_addr_d;
    assign bus.ram_wdata     = ram_wdata_d;
    assign bus.ram_be        = ram_be_d;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_axi4_slave_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_slave_mem_arbiter
//
// Two arbiter instances: dut0 (TURNAROUND = 0) and dut1 (TURNAROUND = 1),
// each with its own behavioural single-port RAM. Read returns of dut0 are
// checked by a scoreboard monitor against hand-computed values and the
// expected arrival cycle; grants and RAM commands are checked directly.
// ---------------------------------------------------------------------------
module tb_axi4_slave_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 12;
    localparam int BW = DW / 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    axi4_slave_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_BITS(MB)) if0 ();
    axi4_slave_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_BITS(MB)) if1 ();

    axi4_slave_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_BITS(MB),
        .MAX_WR_STREAK(4), .TURNAROUND(0)
    ) dut0 (
        .CLK(CLK),
        .RST(RST),
        .bus(if0)
    );

    axi4_slave_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_BITS(MB),
        .MAX_WR_STREAK(4), .TURNAROUND(1)
    ) dut1 (
        .CLK(CLK),
        .RST(RST),
        .bus(if1)
    );

    // Behavioural RAMs: byte-enabled write, 1-cycle registered read.
    logic [DW-1:0] mem0 [0:(1<<MB)-1];
    logic [DW-1:0] mem1 [0:(1<<MB)-1];

    always @(posedge CLK) begin
        if (if0.ram_en === 1'b1) begin
            if (if0.ram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (if0.ram_be[b]) mem0[if0.ram_addr][8*b +: 8] <= if0.ram_wdata[8*b +: 8];
                end
            end else begin
                if0.ram_rdata <= mem0[if0.ram_addr];
            end
        end
    end

    always @(posedge CLK) begin
        if (if1.ram_en === 1'b1) begin
            if (if1.ram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (if1.ram_be[b]) mem1[if1.ram_addr][8*b +: 8] <= if1.ram_wdata[8*b +: 8];
                end
            end else begin
                if1.ram_rdata <= mem1[if1.ram_addr];
            end
        end
    end

    // Bookkeeping
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb_q[$];

    logic [0:9] starve_pat = 10'b1111011110;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Scoreboard monitor for dut0 read returns.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RST === 1'b0 && if0.rd_data_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rd_valid", 64'(if0.rd_data_valid), 64'(1'b0));
            end else begin
                e = sb_q.pop_front();
                check("rd_data", 64'(if0.rd_data), 64'(e.data));
                check("rd_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Sample dut0 in the middle of the current cycle; queue the expected
    // read return when a read grant is expected.
    task automatic sample0(input string name, input bit ew, input bit er, input logic [DW-1:0] rexp);
        @(negedge CLK);
        check({name, "_wr_gnt"}, 64'(if0.wr_gnt), 64'(ew));
        check({name, "_rd_gnt"}, 64'(if0.rd_gnt), 64'(er));
        check({name, "_ram_en"}, 64'(if0.ram_en), 64'(ew | er));
        if (er) sb_q.push_back('{data: rexp, due: cyc + 2});
    endtask

    task automatic sample1(input string name, input bit ew, input bit er);
        @(negedge CLK);
        check({name, "_wr_gnt"}, 64'(if1.wr_gnt), 64'(ew));
        check({name, "_rd_gnt"}, 64'(if1.rd_gnt), 64'(er));
        check({name, "_ram_en"}, 64'(if1.ram_en), 64'(ew | er));
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        // Reset with both requests active
        RST = 1'b1;
        if0.wr_req = 1'b1; if0.wr_addr = '0; if0.wr_data = '0; if0.wr_byte_en = '0;
        if0.rd_req = 1'b1; if0.rd_addr = '0;
        if1.wr_req = 1'b0; if1.wr_addr = '0; if1.wr_data = '0; if1.wr_byte_en = '0;
        if1.rd_req = 1'b0; if1.rd_addr = '0;
        repeat (2) begin
            @(negedge CLK);
            check("rst_wr_gnt",   64'(if0.wr_gnt),        64'(1'b0));
            check("rst_rd_gnt",   64'(if0.rd_gnt),        64'(1'b0));
            check("rst_ram_en",   64'(if0.ram_en),        64'(1'b0));
            check("rst_rd_valid", 64'(if0.rd_data_valid), 64'(1'b0));
            check("rst_rd_data",  64'(if0.rd_data),       64'(0));
            check("rst_ram_addr", 64'(if0.ram_addr),      64'(0));
        end
        adv();
        RST = 1'b0;
        if0.wr_req = 1'b0;
        if0.rd_req = 1'b0;
        sample0("idle0", 0, 0, '0); adv();

        // Write 0x10 then read it back
        if0.wr_req = 1'b1; if0.wr_addr = 32'h10; if0.wr_data = 32'hDEADBEEF; if0.wr_byte_en = 4'hF;
        sample0("wr1", 1, 0, '0);
        check("wr1_ram_we",    64'(if0.ram_we),    64'(1'b1));
        check("wr1_ram_addr",  64'(if0.ram_addr),  64'(12'h010));
        check("wr1_ram_wdata", 64'(if0.ram_wdata), 64'(32'hDEADBEEF));
        check("wr1_ram_be",    64'(if0.ram_be),    64'(4'hF));
        adv();
        if0.wr_req = 1'b0;
        if0.rd_req = 1'b1; if0.rd_addr = 32'h10;
        sample0("rd1", 0, 1, 32'hDEADBEEF);
        check("rd1_ram_we", 64'(if0.ram_we), 64'(1'b0));
        check("rd1_ram_be", 64'(if0.ram_be), 64'(4'h0));
        adv();
        if0.rd_req = 1'b0;
        sample0("idle1", 0, 0, '0);
        check("hold_ram_addr", 64'(if0.ram_addr), 64'(12'h010));
        adv();
        sample0("idle2", 0, 0, '0); adv();

        // Byte enables and address truncation
        if0.wr_req = 1'b1; if0.wr_addr = 32'h005; if0.wr_data = 32'h11223344; if0.wr_byte_en = 4'hF;
        sample0("pre", 1, 0, '0); adv();
        if0.wr_addr = 32'hFFFF_F005; if0.wr_data = 32'hAABBCCDD; if0.wr_byte_en = 4'b0101;
        sample0("wr_be", 1, 0, '0);
        check("be_ram_addr", 64'(if0.ram_addr), 64'(12'h005));
        check("be_ram_be",   64'(if0.ram_be),   64'(4'b0101));
        adv();
        if0.wr_req = 1'b0;
        if0.rd_req = 1'b1; if0.rd_addr = 32'h005;
        sample0("rd_be", 0, 1, 32'h11BB33DD); adv();
        if0.rd_req = 1'b0;
        repeat (2) begin sample0("idle3", 0, 0, '0); adv(); end

        // Starvation guard: both requests held, pattern W W W W R W W W W R.
        // Reads of 0x20 return the latest write already granted.
        k = 0;
        if0.wr_req = 1'b1; if0.wr_addr = 32'h20; if0.wr_data = 32'h100; if0.wr_byte_en = 4'hF;
        if0.rd_req = 1'b1; if0.rd_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            sample0($sformatf("starve%0d", i), starve_pat[i], !starve_pat[i], 32'h100 + 32'(k) - 32'd1);
            adv();
            if (starve_pat[i]) begin
                k++;
                if0.wr_data = 32'h100 + 32'(k);
            end
        end
        if0.wr_req = 1'b0;
        if0.rd_req = 1'b0;
        repeat (3) begin sample0("idle4", 0, 0, '0); adv(); end

        // Turnaround instance
        if1.rd_req = 1'b1;
        sample1("t_idle_rd", 0, 1); adv();
        if1.rd_req = 1'b0;
        sample1("t_idle", 0, 0); adv();
        if1.wr_req = 1'b1; if1.wr_addr = 32'h30; if1.wr_data = 32'h5A5A5A5A; if1.wr_byte_en = 4'hF;
        sample1("t_wr", 1, 0); adv();
        if1.wr_req = 1'b0;
        if1.rd_req = 1'b1; if1.rd_addr = 32'h30;
        sample1("t_dead_wr2rd", 0, 0); adv();
        sample1("t_rd", 0, 1); adv();
        if1.rd_req = 1'b0;
        if1.wr_req = 1'b1;
        sample1("t_dead_rd2wr", 0, 0); adv();
        sample1("t_wr2", 1, 0); adv();
        if1.wr_req = 1'b0;
        sample1("t_idle2", 0, 0); adv();

        // Reset in the cycle after a read grant cancels the return
        if0.rd_req = 1'b1; if0.rd_addr = 32'h10;
        @(negedge CLK);
        check("mr_rd_gnt", 64'(if0.rd_gnt), 64'(1'b1));
        adv();
        if0.rd_req = 1'b0;
        RST = 1'b1;
        adv();
        RST = 1'b0;
        @(negedge CLK);
        check("mr_no_valid", 64'(if0.rd_data_valid), 64'(1'b0));
        check("mr_rd_data",  64'(if0.rd_data),       64'(0));
        adv();
        repeat (3) begin sample0("idle5", 0, 0, '0); adv(); end

        check("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
